aes_mode_ctrl: RTL

- Parametrised chaining-mode engine that sits between the register/DMEM layer and a single-block AES core. It drives the core through its ld/done handshake.
- Adds ECB, CBC and CTR modes, with a per-block streaming interface and an output buffer of configurable depth.
- Lets firmware push consecutive blocks without reloading an IV or counter for each block.
- Core-agnostic: `core_dir` selects the cipher or inverse-cipher core, which are muxed outside this block.

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_blk_fifo.sv | 36 +++
 rtl/aes_mode_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared encodings and types for the AES chaining-mode controller.
package aes_pkg;
    localparam int AES_BLK_W = 128;
    typedef logic [AES_BLK_W-1:0] blk_t;
    typedef enum logic [1:0] {AES_ECB = 2'b00, AES_CBC = 2'b01, AES_CTR = 2'b10} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: synchronous FIFO with occupancy count; head reads as zero when empty.
module aes_blk_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;
    assign w_pop  = i_pop & (r_cnt != '0);
    assign w_push = i_push & ((r_cnt != (AW+1)'(DEPTH)) | w_pop);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_data;
    assign o_data  = (r_cnt != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;
endmodule

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR chaining engine around a single-block AES core;
// one block in flight, results queued in an output buffer.
module aes_mode_ctrl
    import aes_pkg::*;
#(
    parameter int BLK_W     = 128,
    parameter int CTR_W     = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_dir,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             cfg_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             core_ld,
    output logic             core_dir,
    output logic [BLK_W-1:0] core_text_in,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_text_out,
    output logic [15:0]      blk_cnt,
    output logic             idle
);
    localparam int OW = $clog2(OUT_DEPTH) + 1;
    localparam logic [OW-1:0] OCC_MAX = OW'(OUT_DEPTH);

    state_t           r_state, w_next;
    mode_t            r_mode;
    logic             r_dir, r_live;
    logic [BLK_W-1:0] r_chain, r_din, r_text, w_text, w_res;
    logic [OW-1:0]    r_occ, w_fifo_cnt;
    logic [15:0]      r_blk_cnt;
    logic             w_acc, w_pop, w_done, w_cbc_enc, w_cbc_dec;

    assign w_acc     = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_done    = (r_state == S_WAIT) & core_done;
    assign w_cbc_enc = (r_mode == AES_CBC) & !r_dir;
    assign w_cbc_dec = (r_mode == AES_CBC) & r_dir;
    assign w_text    = (r_mode == AES_CTR) ? r_chain : w_cbc_enc ? in_data ^ r_chain : in_data;
    assign w_res     = (r_mode == AES_CTR) ? core_text_out ^ r_din :
                       w_cbc_dec ? core_text_out ^ r_chain : core_text_out;

    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb
        w_next = (r_state == S_IDLE) ? (w_acc ? S_LOAD : S_IDLE) :
                 (r_state == S_LOAD) ? S_WAIT : (w_done ? S_IDLE : S_WAIT);

    // Occupancy includes the in-flight block, so a finished block always has a slot.
    always_comb begin
        in_ready = r_live & (r_state == S_IDLE) & !cfg_start & (r_occ < OCC_MAX);
        core_ld  = (r_state == S_LOAD);
        core_dir = (r_mode != AES_CTR) & r_dir;
        idle     = (r_state == S_IDLE) & !out_valid;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_mode    <= AES_ECB;
            r_dir     <= 1'b0;
            r_chain   <= '0;
            r_din     <= '0;
            r_text    <= '0;
            r_occ     <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_live <= 1'b1;
            r_occ  <= r_occ + OW'(w_acc) - OW'(w_pop);
            if (cfg_start && r_state == S_IDLE) begin
                r_mode    <= (cfg_mode == 2'b11) ? AES_ECB : mode_t'(cfg_mode);
                r_dir     <= cfg_dir;
                r_chain   <= cfg_iv;
                r_blk_cnt <= '0;
            end
            if (w_acc) begin
                r_din  <= in_data;
                r_text <= w_text;
            end
            if (w_done) begin
                r_blk_cnt <= (r_blk_cnt == 16'hFFFF) ? r_blk_cnt : r_blk_cnt + 16'd1;
                if (w_cbc_enc) r_chain <= core_text_out;
                else if (w_cbc_dec) r_chain <= r_din;
                else if (r_mode == AES_CTR) r_chain[CTR_W-1:0] <= r_chain[CTR_W-1:0] + CTR_W'(1);
            end
        end
    end

    aes_blk_fifo #(.WIDTH(BLK_W), .DEPTH(OUT_DEPTH)) u_fifo (
        .i_clk   (mclk),
        .i_rst_n (rst_n),
        .i_push  (w_done),
        .i_data  (w_res),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_count (w_fifo_cnt)
    );

    assign out_valid    = (w_fifo_cnt != '0);
    assign core_text_in = r_text;
    assign blk_cnt      = r_blk_cnt;
endmodule
